// File: rtl/divisor_sequencial_8bits.sv
`default_nettype none
// ============================================================================
// Module      : divisor_sequencial_8bits
// Description : 8-bit unsigned restoring divider, one quotient bit per cycle,
//               with start/busy/done handshake and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_sequencial_8bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic [7:0] dividendo,
  input  logic [7:0] divisor,
  output logic [7:0] quociente,
  output logic [7:0] resto,
  output logic       ocupado,
  output logic       pronto,
  output logic       div_zero
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  estado_t    r_estado;
  logic [7:0] r_d;
  logic [7:0] r_v;
  logic [7:0] r_r;
  logic [2:0] r_cnt;

  logic [8:0] w_t;
  logic [7:0] w_dif;
  logic       w_borrow;
  logic       w_qbit;
  logic [7:0] w_r_next;
  logic [7:0] w_d_next;

  // A set T[8] means T >= 256 > V, so no borrow and the 8-bit wrapped difference is exact.
  assign w_t      = {r_r, r_d[7]};
  assign w_dif    = w_t[7:0] - r_v;
  assign w_borrow = ~w_t[8] & (w_t[7:0] < r_v);
  assign w_qbit   = ~w_borrow;
  assign w_r_next = w_borrow ? w_t[7:0] : w_dif;
  assign w_d_next = {r_d[6:0], w_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= OCIOSO;
      r_d       <= 8'd0;
      r_v       <= 8'd0;
      r_r       <= 8'd0;
      r_cnt     <= 3'd0;
      quociente <= 8'd0;
      resto     <= 8'd0;
      div_zero  <= 1'b0;
      pronto    <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (r_estado)
        // FIM hands over to OCIOSO on this edge; a start present here is taken
        // as the first idle sample, giving one division every 9 cycles.
        OCIOSO, FIM: begin
          r_estado <= OCIOSO;
          ocupado  <= 1'b0;
          if (iniciar) begin
            r_d     <= dividendo;
            r_v     <= divisor;
            r_r     <= 8'd0;
            r_cnt   <= 3'd0;
            ocupado <= 1'b1;
            if (divisor == 8'd0) begin
              quociente <= 8'hFF;
              resto     <= dividendo;
              div_zero  <= 1'b1;
              pronto    <= 1'b1;
              r_estado  <= FIM;
            end else begin
              r_estado <= CALCULA;
            end
          end
        end
        CALCULA: begin
          r_d   <= w_d_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            quociente <= w_d_next;
            resto     <= w_r_next;
            div_zero  <= 1'b0;
            pronto    <= 1'b1;
            r_estado  <= FIM;
          end
        end
        default: begin
          r_estado <= OCIOSO;
          ocupado  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/divisor_sequencial_8bits.md
# divisor_sequencial_8bits

- Sequential restoring divider: 8-bit unsigned dividend divided by 8-bit unsigned divisor, giving an 8-bit quotient and an 8-bit remainder.
- Each of 8 cycles performs one shift-subtract step on a 9-bit trial subtraction and resolves one quotient bit, MSB first.
- A start/busy/done handshake sequences the step. It sits between the calculator's operand registers and the display/result path.
- Division by zero is detected up front and reported by flag, not computed.

## Interface
Parameters: none (width fixed at 8 bits).

- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- iniciar  input  1  start request, sampled on rising clk
- dividendo  input  8  dividend, sampled when a start is accepted
- divisor  input  8  divisor, sampled when a start is accepted
- quociente  output  8  registered quotient, held until the next accepted start completes
- resto  output  8  registered remainder, held likewise
- ocupado  output  1  high while a division is in progress (states CALCULA and FIM)
- pronto  output  1  one-cycle pulse: results valid and just updated
- div_zero  output  1  registered; set with results when the divisor was 0, cleared when a non-zero division completes

## Operation
- States: OCIOSO, CALCULA, FIM. Reset state is OCIOSO.
- OCIOSO:
  - iniciar=1 is accepted.
  - Latch dividendo into shift register D, latch divisor into V, clear partial remainder R (8 bits), clear counter (3 bits).
  - If divisor==0, go to FIM with the zero flag pending. Otherwise go to CALCULA.
- CALCULA, one step per edge:
  - Form trial minuend T = {R, D[7]} (9 bits).
  - Compute T − {1'b0, V} with 9-bit borrow.
  - No borrow: R ← low 8 bits of the difference, quotient bit = 1.
  - Borrow: R ← low 8 bits of T, quotient bit = 0.
  - D ← {D[6:0], quotient bit}, so D accumulates the quotient.
  - The counter increments. On the 8th step (counter==7), load quociente ← new D, resto ← new R, div_zero ← 0, and go to FIM.
- Divide by zero (OCIOSO→FIM transition): load quociente ← 8'hFF, resto ← latched dividend, div_zero ← 1.
- FIM: pronto=1 for exactly one cycle, then unconditionally go to OCIOSO.
- iniciar is ignored in CALCULA and FIM, with no queuing. A start held high through FIM is accepted on the first OCIOSO cycle.
- Inputs dividendo/divisor may change freely after acceptance without affecting the result.
- Reset (asserted at any time, including mid-division) immediately forces:
  - state OCIOSO
  - quociente=0, resto=0, div_zero=0, pronto=0, ocupado=0
  - internal R, D, V and counter cleared
  - the in-flight division is discarded.

## Timing
- Start accepted at edge E0.
- ocupado=1 from after E0 until after E9.
- Steps run at E1..E8. Outputs are updated at E8.
- pronto=1 during the cycle between E8 and E9. The state is OCIOSO after E9.
- Next start can be accepted at E9, giving a throughput of one division per 9 cycles.
- Divide by zero: start at E0, outputs updated and FIM entered at E0, pronto high E0..E1, OCIOSO after E1.
- Outputs change only at completion edges or reset, never during CALCULA.

## Test plan
- Reset, then 200/7: start at E0 → pronto during E8–E9, quociente=28, resto=4, div_zero=0, ocupado low after E9.
- Boundary operands, run back-to-back with iniciar held high:
  - 255/1 → 255 r 0
  - 255/255 → 1 r 0
  - 5/9 → 0 r 5
  - 0/3 → 0 r 0
  - each result pronto exactly 9 cycles apart.
- 128/0 → pronto one cycle after the start edge, quociente=8'hFF, resto=128, div_zero=1. A following 9/3 returns 3 r 0 with div_zero cleared.
- Start 100/10, pulse iniciar and change operands to 50/2 during CALCULA → the new start is ignored, result 10 r 0, quociente/resto unchanged until E8.
- Start 250/3, assert rst_n=0 asynchronously at step 4 → all outputs 0 immediately without a clock edge. After release, 17/4 gives 4 r 1 with normal latency.
- Exhaustive sweep of all 65,280 non-zero-divisor pairs against a reference model → quociente=A/B, resto=A%B, pronto once per operation.
